// File: rtl/deconvolve.sv
// Streaming inverse of a DEPTH-wide running-sum filter: e[n] = S[n] - S[n-1] + e[n-DEPTH].
// Define DECONVOLVE_SKID_EN for a 2-entry output skid buffer with a registered in_ready.
module deconvolve #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] in_sum,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_entry,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         primed
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e         state_q;
  logic [W-1:0]   hist_q [DEPTH];
  logic [W-1:0]   s_prev_q;
  logic [W-1:0]   head_q;
  logic [CW-1:0]  count_q;
  logic           out_valid_q;
  logic           primed_q;
`ifdef DECONVOLVE_SKID_EN
  logic [W-1:0]   tail_q;
  logic           in_ready_q;
`endif

  logic           accept;
  logic           drain;
  logic [W-1:0]   diff;
  logic [W-1:0]   entry;

  // Wrapping W-bit arithmetic is what makes the inversion exact.
  assign diff  = in_sum - s_prev_q;
  assign entry = diff + hist_q[DEPTH-1];

`ifdef DECONVOLVE_SKID_EN
  assign in_ready = in_ready_q;
`else
  assign in_ready = ~out_valid_q | out_ready;
`endif

  assign accept    = in_valid & in_ready;
  assign drain     = out_valid_q & out_ready;
  assign out_entry = head_q;
  assign out_valid = out_valid_q;
  assign primed    = primed_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      s_prev_q    <= '0;
      head_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
`ifdef DECONVOLVE_SKID_EN
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
`endif
    end else if (clear) begin
      // Clear wins over a coincident accept; that sample is dropped.
      state_q     <= StEmpty;
      s_prev_q    <= '0;
      head_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      primed_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
`ifdef DECONVOLVE_SKID_EN
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
`endif
    end else begin
      if (accept) begin
        s_prev_q  <= in_sum;
        hist_q[0] <= entry;
        for (int i = 1; i < DEPTH; i++) hist_q[i] <= hist_q[i-1];
        if (count_q != CW'(DEPTH)) count_q <= count_q + 1'b1;
        if (count_q >= CW'(DEPTH - 1)) primed_q <= 1'b1;
      end

`ifdef DECONVOLVE_SKID_EN
      case (state_q)
        StEmpty: begin
          if (accept) begin
            head_q      <= entry;
            state_q     <= StOne;
            out_valid_q <= 1'b1;
          end
        end
        StOne: begin
          if (accept && drain) begin
            head_q <= entry;
          end else if (accept) begin
            tail_q     <= entry;
            state_q    <= StTwo;
            in_ready_q <= 1'b0;
          end else if (drain) begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
          end
        end
        StTwo: begin
          // in_ready is low here, so only a drain can happen.
          if (drain) begin
            head_q     <= tail_q;
            state_q    <= StOne;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= StEmpty;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
`else
      case (state_q)
        StEmpty: begin
          if (accept) begin
            head_q      <= entry;
            state_q     <= StOne;
            out_valid_q <= 1'b1;
          end
        end
        StOne: begin
          if (accept) begin
            head_q <= entry;
          end else if (drain) begin
            state_q     <= StEmpty;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StEmpty;
          out_valid_q <= 1'b0;
        end
      endcase
`endif
    end
  end

endmodule
